usb_port_sched: RTL and testbench

USB_PORT_SCHED -- requirements
Module: usb_port_sched

---
 rtl/usb_if_pkg.sv | 28 ++
 rtl/usb_rr_arb3.sv | 24 ++
 rtl/usb_port_sched.sv | 131 +++++++++++++
 tb/tb_usb_port_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_if_pkg.sv
// Shared encodings for the FX3 port scheduler: FSM states, port indices and FIFOADDR codes.
package usb_if_pkg;

  typedef enum logic [2:0] {StIdle, StAddr, StStrt, StWait, StGap} sched_state_e;

  localparam logic [1:0] PortDpi = 2'd0;
  localparam logic [1:0] PortDpo = 2'd1;
  localparam logic [1:0] PortCpi = 2'd2;

  localparam logic [1:0] FifoAdrDpi = 2'b00;
  localparam logic [1:0] FifoAdrDpo = 2'b01;
  localparam logic [1:0] FifoAdrCpi = 2'b10;

  function automatic logic [1:0] onehot_to_port(input logic [2:0] oh);
    if (oh[2]) return PortCpi;
    if (oh[1]) return PortDpo;
    return PortDpi;
  endfunction

  function automatic logic [1:0] port_fifoadr(input logic [1:0] port);
    case (port)
      PortDpo: return FifoAdrDpo;
      PortCpi: return FifoAdrCpi;
      default: return FifoAdrDpi;
    endcase
  endfunction

endpackage

// File: rtl/usb_rr_arb3.sv
// Three-way round-robin picker: search starts at the port after the last served one.
module usb_rr_arb3
  import usb_if_pkg::*;
(
  input  logic [2:0] eligible,
  input  logic [1:0] last,
  output logic [2:0] winner
);

  logic [1:0] first, second, third;

  always_comb begin
    case (last)
      PortDpi: begin first = PortDpo; second = PortCpi; third = PortDpi; end
      PortDpo: begin first = PortCpi; second = PortDpi; third = PortDpo; end
      default: begin first = PortDpi; second = PortDpo; third = PortCpi; end
    endcase
    winner = '0;
    if (eligible[first]) winner[first] = 1'b1;
    else if (eligible[second]) winner[second] = 1'b1;
    else if (eligible[third]) winner[third] = 1'b1;
  end

endmodule

// File: rtl/usb_port_sched.sv
// FX3 slave-FIFO bus scheduler: round-robin grant, address setup, start pulse,
// done/timeout wait and turnaround gap.
module usb_port_sched
  import usb_if_pkg::*;
#(
  parameter int unsigned ADDR_SETUP = 2,
  parameter int unsigned TURN_CYC   = 1,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [2:0] en_i,
  input  logic [2:0] req_i,
  input  logic [2:0] done_i,
  output logic [2:0] strt_o,
  output logic [2:0] abort_o,
  output logic [1:0] fifoadr_o,
  output logic [2:0] grant_o,
  output logic       busy_o,
  output logic [7:0] err_cnt_o
);

  localparam logic [15:0] AddrLast = 16'(ADDR_SETUP - 1);
  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);
  localparam logic [15:0] GapLast  = 16'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam bit          SkipGap  = (TURN_CYC == 0);

  sched_state_e state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [2:0]   grant_q, grant_d;
  logic [1:0]   fifoadr_q, fifoadr_d;
  logic [1:0]   last_q, last_d;
  logic [7:0]   err_q, err_d;
  logic [2:0]   winner;
  logic         leave;

  usb_rr_arb3 u_arb (
    .eligible (en_i & req_i),
    .last     (last_q),
    .winner   (winner)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    grant_d   = grant_q;
    fifoadr_d = fifoadr_q;
    last_d    = last_q;
    err_d     = err_q;
    strt_o    = '0;
    abort_o   = '0;
    leave     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (winner != 3'b000) begin
          grant_d   = winner;
          fifoadr_d = port_fifoadr(onehot_to_port(winner));
          state_d   = StAddr;
        end
      end
      StAddr: begin
        if (cnt_q == AddrLast) begin
          cnt_d   = '0;
          state_d = StStrt;
        end
      end
      StStrt: begin
        strt_o  = grant_q;
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Done on the expiry cycle takes priority over the abort.
        if ((done_i & grant_q) != 3'b000) begin
          leave = 1'b1;
        end else if (cnt_q == WaitLast) begin
          abort_o = grant_q;
          leave   = 1'b1;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
        if (leave) begin
          last_d = onehot_to_port(grant_q);
          cnt_d  = '0;
          if (SkipGap) begin
            grant_d = '0;
            state_d = StIdle;
          end else begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      grant_q   <= '0;
      fifoadr_q <= FifoAdrDpi;
      last_q    <= PortCpi;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      fifoadr_q <= fifoadr_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  assign grant_o   = grant_q;
  assign fifoadr_o = fifoadr_q;
  assign busy_o    = (state_q != StIdle);
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_usb_port_sched.sv
// Bench for usb_port_sched: directed scenarios plus random traffic, every cycle
// compared against a timeline model of a transfer (elapsed cycles since grant).
module tb_usb_port_sched;

  localparam int AS = 2;
  localparam int TC = 1;
  localparam int TO = 1024;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] en, req, done;
  logic [2:0] strt, abort, grant;
  logic [1:0] fifoadr;
  logic       busy;
  logic [7:0] err_cnt;

  usb_port_sched #(
    .ADDR_SETUP (AS),
    .TURN_CYC   (TC),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .en_i      (en),
    .req_i     (req),
    .done_i    (done),
    .strt_o    (strt),
    .abort_o   (abort),
    .fifoadr_o (fifoadr),
    .grant_o   (grant),
    .busy_o    (busy),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: owner (-1 = bus free), elapsed cycles since entering address setup,
  // elapsed value at which the transfer ended (-1 = still waiting).
  int m_owner, m_el, m_end, m_last, m_err, m_fifo;
  bit m_valid = 1'b0;

  function automatic void model_reset();
    m_owner = -1; m_el = 0; m_end = -1; m_last = 2; m_err = 0; m_fifo = 0;
    m_valid = 1'b1;
  endfunction

  function automatic void model_step(input logic [2:0] e, input logic [2:0] r,
                                     input logic [2:0] d);
    logic [2:0] elig;
    bit found;
    elig  = e & r;
    found = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= 3; k++) begin
        int p;
        p = (m_last + k) % 3;
        if (!found && elig[p]) begin
          found = 1'b1; m_owner = p; m_fifo = p; m_el = 0; m_end = -1;
        end
      end
    end else begin
      if (m_end < 0 && m_el > AS) begin
        if (d[m_owner]) begin
          m_end = m_el; m_last = m_owner;
        end else if (m_el == AS + TO) begin
          m_end = m_el; m_last = m_owner;
          if (m_err < 255) m_err++;
        end
      end
      m_el++;
      if (m_end >= 0 && m_el > m_end + TC) m_owner = -1;
    end
  endfunction

  logic [2:0] o_strt, o_abort, o_grant;
  logic [1:0] o_fifo;
  logic       o_busy;
  logic [7:0] o_err;
  int         cyc = 0;

  task automatic step(input logic [2:0] e, input logic [2:0] r, input logic [2:0] d,
                      input logic rn);
    logic [2:0] g_exp, s_exp, a_exp;
    @(negedge clk);
    en = e; req = r; done = d; rstn = rn;
    #1;
    o_strt = strt; o_abort = abort; o_grant = grant;
    o_fifo = fifoadr; o_busy = busy; o_err = err_cnt;
    if (m_valid) begin
      g_exp = '0; s_exp = '0; a_exp = '0;
      if (m_owner >= 0) begin
        g_exp = 3'(1 << m_owner);
        if (m_el == AS) s_exp = g_exp;
        if (m_end < 0 && m_el == AS + TO && !d[m_owner]) a_exp = g_exp;
      end
      check("m_grant", o_grant, g_exp);
      check("m_busy", o_busy, m_owner >= 0);
      check("m_fifoadr", o_fifo, m_fifo);
      check("m_strt", o_strt, s_exp);
      check("m_abort", o_abort, a_exp);
      check("m_err_cnt", o_err, m_err);
    end
    if (!rn) model_reset();
    else if (m_valid) model_step(e, r, d);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 3'b000, 3'b000, 1'b0);
  endtask

  int         c, s, a, n, since, nab, nstrt;
  logic [2:0] r, d, g, g2;
  logic [2:0] order [4];

  initial begin
    rstn = 1'b0; en = '0; req = '0; done = '0;

    // Reset release and basic latency
    do_reset(3);
    check("t1_reset_busy", o_busy, 1'b0);
    cyc = 0;
    while (cyc < 23) begin
      c = cyc;
      r = (c == 10) ? 3'b001 : 3'b000;
      d = (c == 20) ? 3'b001 : 3'b000;
      step(3'b111, r, d, 1'b1);
      if (c == 11) begin
        check("t1_fifoadr", o_fifo, 2'b00);
        check("t1_grant", o_grant, 3'b001);
      end
      if (c == 12) check("t1_strt_early", o_strt, 3'b000);
      if (c == 13) check("t1_strt", o_strt, 3'b001);
      if (c == 21) check("t1_busy_gap", o_busy, 1'b1);
      if (c == 22) check("t1_busy_idle", o_busy, 1'b0);
    end

    // Round-robin order with all ports requesting
    do_reset(2);
    n = 0; since = -1; g = '0;
    for (int i = 0; i < 300 && n < 4; i++) begin
      if (since >= 0) since++;
      d = (since == 5) ? g : 3'b000;
      if (since == 5) since = -1;
      step(3'b111, 3'b111, d, 1'b1);
      if (o_strt != 3'b000) begin
        order[n] = o_strt; n++; since = 0; g = o_strt;
      end
    end
    check("t2_count", n, 4);
    check("t2_order0", order[0], 3'b001);
    check("t2_order1", order[1], 3'b010);
    check("t2_order2", order[2], 3'b100);
    check("t2_order3", order[3], 3'b001);

    // Timeout on DPI, then DPO served
    do_reset(2);
    s = -1; a = -1; g2 = '0;
    for (int i = 0; i < 1400 && g2 == 3'b000; i++) begin
      c = cyc;
      step(3'b111, 3'b011, 3'b000, 1'b1);
      if (o_strt != 3'b000) begin
        if (s < 0) s = c;
        else if (a >= 0) g2 = o_strt;
      end
      if (o_abort != 3'b000 && a < 0) begin
        a = c;
        check("t3_abort_val", o_abort, 3'b001);
        check("t3_err_at_abort", o_err, 0);
      end
    end
    check("t3_abort_time", a - s, TO);
    check("t3_err_after", o_err, 1);
    check("t3_next_grant", g2, 3'b010);

    // Done on the expiry cycle wins
    do_reset(2);
    s = -1; nab = 0;
    for (int i = 0; i < 1100; i++) begin
      c = cyc;
      d = (s >= 0 && c == s + TO) ? 3'b001 : 3'b000;
      r = (i == 0) ? 3'b001 : 3'b000;
      step(3'b111, r, d, 1'b1);
      if (o_strt != 3'b000 && s < 0) s = c;
      if (o_abort != 3'b000) nab++;
    end
    check("t4_started", s >= 0, 1'b1);
    check("t4_no_abort", nab, 0);
    check("t4_err", o_err, 0);
    check("t4_idle", o_busy, 1'b0);

    // Foreign done ignored; disabled ports never start
    do_reset(2);
    step(3'b111, 3'b001, 3'b000, 1'b1);
    for (int i = 0; i < 10 && o_strt == 3'b000; i++) step(3'b111, 3'b000, 3'b000, 1'b1);
    check("t5_strt", o_strt, 3'b001);
    for (int i = 0; i < 10; i++) step(3'b000, 3'b000, 3'b010, 1'b1);
    check("t5_still_busy", o_busy, 1'b1);
    check("t5_still_grant", o_grant, 3'b001);
    step(3'b111, 3'b000, 3'b001, 1'b1);
    step(3'b111, 3'b000, 3'b000, 1'b1);
    step(3'b111, 3'b000, 3'b000, 1'b1);
    check("t5_done_idle", o_busy, 1'b0);
    nstrt = 0;
    for (int i = 0; i < 30; i++) begin
      step(3'b000, 3'b111, 3'b000, 1'b1);
      if (o_strt != 3'b000 || o_busy) nstrt++;
    end
    check("t5_no_strt", nstrt, 0);

    // Reset during WAIT
    do_reset(2);
    step(3'b111, 3'b010, 3'b000, 1'b1);
    for (int i = 0; i < 10 && o_strt == 3'b000; i++) step(3'b111, 3'b000, 3'b000, 1'b1);
    step(3'b111, 3'b000, 3'b000, 1'b1);
    step(3'b111, 3'b000, 3'b000, 1'b1);
    check("t6_fifo_before", o_fifo, 2'b01);
    step(3'b111, 3'b000, 3'b000, 1'b0);
    check("t6_abort_rst", o_abort, 3'b000);
    step(3'b111, 3'b111, 3'b000, 1'b1);
    check("t6_grant", o_grant, 3'b000);
    check("t6_busy", o_busy, 1'b0);
    check("t6_fifo", o_fifo, 2'b00);
    check("t6_strt", o_strt, 3'b000);
    check("t6_abort", o_abort, 3'b000);
    check("t6_err", o_err, 0);
    step(3'b111, 3'b000, 3'b000, 1'b1);
    check("t6_ptr_dpi_first", o_grant, 3'b001);

    // Random traffic against the model
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] re, rr, rd;
      logic       rn;
      re = ($urandom_range(3) == 0) ? 3'($urandom) : 3'b111;
      rr = 3'($urandom);
      rd = ($urandom_range(5) == 0) ? 3'($urandom) : 3'b000;
      rn = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
      step(re, rr, rd, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
